// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with branch/jump next-PC, stall hold, end-of-program halt and retire counter
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_MAX = 32'd68,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  input  logic [15:0]      imm,
  input  logic             jump,
  input  logic [25:0]      jtarget,
  output logic [31:0]      pcread,
  output logic [31:0]      pcplus4,
  output logic             valid,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [1:0] {START, RUN, HALT} state_t;
  state_t state;
  logic [31:0] next_pc;
  logic [CNT_W-1:0] cnt_next;
  assign pcplus4 = pcread + 32'd4;
  assign cnt_next = (&instr_count) ? instr_count : instr_count + 1'b1;
  // next fetch address: jump beats taken branch beats sequential
  always_comb
    next_pc = jump ? {pcplus4[31:28], jtarget, 2'b00}
            : (branch && zero) ? pcplus4 + {{14{imm[15]}}, imm, 2'b00}
            : pcplus4;
  // START settles the instruction memory, RUN advances or halts, HALT freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      pcread <= RESET_PC;
      state <= START;
      valid <= 1'b0;
      halted <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        START: begin
          state <= RUN;
          valid <= 1'b1;
        end
        RUN: if (!stall) begin
          instr_count <= cnt_next;
          if (next_pc > PC_MAX) begin
            state <= HALT;
            valid <= 1'b0;
            halted <= 1'b1;
          end else pcread <= next_pc;
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized and directed checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
  logic clk = 0;
  logic reset, stall, branch, zero, jump;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] pcread, pcplus4, pcread2, pcplus42;
  logic valid, halted, valid2, halted2;
  logic [15:0] instr_count;
  logic [2:0] instr_count2;
  int checks = 0, passed = 0;
  int m_st;
  logic [31:0] m_pc;
  int m_cnt, m_cnt2;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero), .imm(imm),
    .jump(jump), .jtarget(jtarget), .pcread(pcread), .pcplus4(pcplus4), .valid(valid),
    .halted(halted), .instr_count(instr_count)
  );

  pc_fetch_unit #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero), .imm(imm),
    .jump(jump), .jtarget(jtarget), .pcread(pcread2), .pcplus4(pcplus42), .valid(valid2),
    .halted(halted2), .instr_count(instr_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic z,
                      input logic [15:0] im, input logic j, input logic [25:0] jt);
    logic [31:0] p4, np;
    reset = r; stall = s; branch = b; zero = z; imm = im; jump = j; jtarget = jt;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_st = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (m_st == 0) m_st = 1;
    else if (m_st == 1 && !s) begin
      p4 = m_pc + 4;
      if (j) np = {p4[31:28], jt, 2'b00};
      else if (b && z) np = p4 + int'($signed(im)) * 4;
      else np = p4;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 7) m_cnt2++;
      if (np > 68) m_st = 2;
      else m_pc = np;
    end
    #1;
    chk("pcread", pcread, m_pc);
    chk("pcplus4", pcplus4, m_pc + 4);
    chk("valid", 32'(valid), 32'(m_st == 1));
    chk("halted", 32'(halted), 32'(m_st == 2));
    chk("instr_count", 32'(instr_count), m_cnt);
    chk("instr_count_sat", 32'(instr_count2), m_cnt2);
    chk("pcread_small", pcread2, m_pc);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 16'h0, 0, 26'h0);
  endtask

  initial begin
    reset = 1; stall = 0; branch = 0; zero = 0; imm = 0; jump = 0; jtarget = 0;
    m_pc = 0; m_st = 0; m_cnt = 0; m_cnt2 = 0;
    step(1, 0, 0, 0, 16'h0, 0, 26'h0);
    chk("reset_pc", pcread, 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    idle(); chk("first_run_pc", pcread, 32'd0); chk("first_run_valid", 32'(valid), 32'd1);
    idle(); chk("seq_pc4", pcread, 32'd4);
    idle(); chk("seq_pc8", pcread, 32'd8); chk("seq_count", 32'(instr_count), 32'd2);
    idle(); chk("seq_pc12", pcread, 32'd12);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 16'h5, 1, 26'h3);
    chk("stall_pc", pcread, 32'd12); chk("stall_count", 32'(instr_count), 32'd3);
    idle(); chk("unstall_pc", pcread, 32'd16);
    step(0, 0, 0, 0, 16'h0, 1, 26'd17); chk("jump_68", pcread, 32'd68);
    step(0, 0, 1, 1, 16'hFFF8, 0, 26'h0); chk("branch_back", pcread, 32'd40);
    step(0, 0, 1, 1, 16'h7, 1, 26'h00000C); chk("jump_priority", pcread, 32'h30);
    step(0, 0, 0, 0, 16'h0, 1, 26'd17);
    step(0, 0, 1, 0, 16'hFFF8, 0, 26'h0);
    chk("halt_pc", pcread, 32'd68); chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 5; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 26'($urandom));
    chk("halt_frozen_pc", pcread, 32'd68); chk("halt_frozen_count", 32'(instr_count), 32'd9);
    step(1, 0, 0, 0, 16'h0, 0, 26'h0);
    chk("rehalt_reset_pc", pcread, 32'd0); chk("rehalt_reset_halted", 32'(halted), 32'd0);
    chk("rehalt_reset_count", 32'(instr_count), 32'd0);
    idle();
    step(0, 0, 0, 0, 16'h0, 1, 26'd10); chk("jump_40", pcread, 32'd40);
    step(1, 0, 1, 1, 16'h4, 0, 26'h0); chk("reset_beats_branch", pcread, 32'd0);
    for (int i = 0; i < 600; i++) begin
      logic r, s, j, b;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 2) == 0);
      step(r, s, b, 1'($urandom), 16'($signed($urandom_range(0, 40)) - 20), j, 26'($urandom_range(0, 20)));
    end
    step(1, 0, 0, 0, 16'h0, 0, 26'h0);
    for (int i = 0; i < 10; i++) idle();
    chk("sat_pc", pcread, 32'd36); chk("sat_count", 32'(instr_count), 32'd9);
    chk("sat_small", 32'(instr_count2), 32'd7);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
